// File: rtl/uart_mmio_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers on the core store path,
// a byte FIFO, and a start/data/stop serialiser with back-to-back frame chaining.
module uart_mmio_tx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy,
    output logic        irq_idle
);

    localparam int unsigned DIV    = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FIFO and status state
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // Serialiser state
    state_t           state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             busy_q;

    logic wr_txdata, wr_status, full, empty, baud_last, pop, push_ok;
    logic unused_bits;

    assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
    assign wr_txdata = we && sel && !addr[2];
    assign wr_status = we && sel && addr[2];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign baud_last = (baud_q == BAUD_W'(DIV - 1));
    // A pop happens when the line is free: from IDLE, or at the last stop-bit cycle
    assign pop       = !empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last));
    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign push_ok   = wr_txdata && (!full || pop);

    assign tx          = tx_q;
    assign tx_busy     = busy_q;
    assign irq_idle    = empty && (state_q == ST_IDLE);
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    // Occupancy and sticky overflow next-state; a clear beats a set
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (wr_txdata && !push_ok) ovf_d = 1'b1;
        if (wr_status && wdata[3]) ovf_d = 1'b0;
    end

    // Register read mux; TXDATA and unselected addresses read as zero
    always_comb begin
        rdata = '0;
        if (sel && addr[2]) begin
            rdata = {16'h0000, 8'(count_q), 4'h0, ovf_q, full, empty, busy_q};
        end
    end

    // FIFO storage (no reset needed; count guards validity)
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata[7:0];
    end

    // FIFO pointers, count and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Frame serialiser: start bit, 8 data bits LSB first, stop bit, DIV cycles each
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        baud_q  <= '0;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            tx_q    <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Bench for uart_mmio_tx: directed register/timing steps plus randomized bytes,
// with a line decoder that checks every transmitted frame against a byte queue.
module tb_uart_mmio_tx;

    localparam int          DIV        = 10;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] BASE       = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;
    logic        irq_idle;

    int checks = 0;
    int errors = 0;

    // Bytes accepted by the peripheral and not yet started on the line
    logic [7:0] m_fifo[$];

    // Line decoder state
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    int         frames = 0;
    logic [7:0] cur_byte = 8'h00;
    bit         bit_ok = 1'b1;
    bit         idle_ok = 1'b1;

    uart_mmio_tx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000),
        .FIFO_DEPTH(FIFO_DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .sel     (sel),
        .rdata   (rdata),
        .tx      (tx),
        .tx_busy (tx_busy),
        .irq_idle(irq_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Store on the core bus; the model sees the byte at the edge that samples it
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit push);
        we = 1'b1;
        addr = a;
        wdata = d;
        @(posedge clk);
        if (push) m_fifo.push_back(d[7:0]);
        #1;
        we = 1'b0;
        addr = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (m_fifo.size() == 0 && !mon_active && tx_busy === 1'b0) done = 1'b1;
        end
        chk("drain_timeout", 32'(done), 32'd1);
    endtask

    // Line decoder: each frame is 10 bit slots of DIV cycles (0, data LSB first, 1)
    always @(negedge clk) begin
        int   idx;
        logic exp_bit;
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt = 0;
                    bit_ok = 1'b1;
                    if (m_fifo.size() == 0) begin
                        chk("spurious_frame", 32'd1, 32'd0);
                        cur_byte = 8'h00;
                    end else begin
                        cur_byte = m_fifo.pop_front();
                    end
                end else if (tx_busy !== 1'b0) begin
                    idle_ok = 1'b0;
                end
            end
            if (mon_active) begin
                idx = mon_cnt / DIV;
                if (idx == 0) exp_bit = 1'b0;
                else if (idx == 9) exp_bit = 1'b1;
                else exp_bit = cur_byte[idx-1];
                if (tx !== exp_bit || tx_busy !== 1'b1) bit_ok = 1'b0;
                if (mon_cnt % DIV == DIV - 1) begin
                    chk($sformatf("frame%0d_byte%02h_slot%0d", frames, cur_byte, idx),
                        32'(bit_ok), 32'd1);
                    bit_ok = 1'b1;
                end
                mon_cnt++;
                if (mon_cnt == 10 * DIV) begin
                    frames++;
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [31:0] s;
        logic [7:0]  b;
        int          off;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rd(BASE + 32'd4, s);
        chk("reset_status", s, 32'h0000_0002);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_irq_idle", 32'(irq_idle), 32'd1);
        rd(32'h0000_0100, s);
        chk("sel_other", 32'(sel), 32'd0);
        chk("rdata_other", s, 32'd0);
        rd(BASE + 32'd2, s);
        chk("sel_txdata_alias", 32'(sel), 32'd1);
        chk("rdata_txdata", s, 32'd0);
        rd(BASE + 32'd8, s);
        chk("sel_next_block", 32'(sel), 32'd0);
        @(posedge clk);
        #1;

        // Single byte 0x55: latency, busy window
        wr(BASE, 32'hDEAD_BE55, 1'b1);
        chk("b55_tx_before", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        chk("b55_tx_start", 32'(tx), 32'd0);
        chk("b55_irq_busy", 32'(irq_idle), 32'd0);
        rd(BASE + 32'd4, s);
        chk("b55_status_after_pop", s, 32'h0000_0003);
        repeat (10 * DIV - 1) @(posedge clk);
        #1;
        chk("b55_busy_last", 32'(tx_busy), 32'd1);
        @(posedge clk);
        #1;
        chk("b55_busy_fall", 32'(tx_busy), 32'd0);
        chk("b55_irq_idle", 32'(irq_idle), 32'd1);
        rd(BASE + 32'd4, s);
        chk("b55_status_end", s, 32'h0000_0002);
        @(posedge clk);
        #1;

        // Back-to-back 0x41, 0x42: no idle cycle between frames
        wr(BASE, 32'h0000_0041, 1'b1);
        wr(BASE + 32'd3, 32'h0000_0042, 1'b1);
        rd(BASE + 32'd4, s);
        chk("b2b_count1", s, 32'h0000_0101);
        repeat (10 * DIV) @(posedge clk);
        #1;
        rd(BASE + 32'd4, s);
        chk("b2b_count0", s, 32'h0000_0003);
        chk("b2b_second_start", 32'(tx), 32'd0);
        repeat (10 * DIV - 1) @(posedge clk);
        #1;
        chk("b2b_busy_last", 32'(tx_busy), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b_busy_fall", 32'(tx_busy), 32'd0);
        @(posedge clk);
        #1;

        // Burst of 9 fills the FIFO, 10th overflows, then clear via STATUS alias
        for (int i = 1; i <= 9; i++) wr(BASE, 32'(i), 1'b1);
        rd(BASE + 32'd4, s);
        chk("burst_full", s, 32'h0000_0805);
        wr(BASE, 32'h0000_000A, 1'b0);
        rd(BASE + 32'd4, s);
        chk("burst_overflow", s, 32'h0000_080D);
        wr(BASE + 32'd4, 32'hFFFF_FFF7, 1'b0);
        rd(BASE + 32'd4, s);
        chk("ovf_kept_bit3_zero", s, 32'h0000_080D);
        wr(BASE + 32'd7, 32'h0000_0008, 1'b0);
        rd(BASE + 32'd4, s);
        chk("ovf_cleared", s, 32'h0000_0805);
        wait_drain(12 * 10 * DIV);
        chk("burst_irq_idle", 32'(irq_idle), 32'd1);

        // Randomized bytes at random spacing and alias offsets, with stray writes
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 12 * DIV)) @(posedge clk);
            #1;
            for (int g = 0; g < 40 * DIV && m_fifo.size() >= FIFO_DEPTH - 2; g++) begin
                @(posedge clk);
                #1;
            end
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) wr(BASE + 32'(8 + off), $urandom, 1'b0);
            b = 8'($urandom);
            wr(BASE + 32'(off), {24'($urandom), b}, 1'b1);
            @(negedge clk);
            #1;
            rd(BASE + 32'(4 + off), s);
            chk($sformatf("rand%0d_status", n), s & 32'hFFFF_FFFE,
                {16'h0000, 8'(m_fifo.size()), 5'h00,
                 1'b0, m_fifo.size() == 0, 1'b0} | {30'd0, m_fifo.size() == FIFO_DEPTH, 1'b0} << 1);
            @(posedge clk);
            #1;
        end
        wait_drain(30 * 10 * DIV);

        // Reset in the middle of the data bits
        wr(BASE, 32'h0000_00C3, 1'b1);
        repeat (1 + DIV + 3 * DIV + 4) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_busy", 32'(tx_busy), 32'd0);
        chk("rst_mid_irq", 32'(irq_idle), 32'd1);
        rd(BASE + 32'd4, s);
        chk("rst_mid_status", s, 32'h0000_0002);
        m_fifo.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        b = 8'($urandom);
        wr(BASE, 32'(b), 1'b1);
        wait_drain(2 * 10 * DIV);

        chk("idle_busy_low", 32'(idle_ok), 32'd1);
        chk("model_empty", 32'(m_fifo.size()), 32'd0);
        chk("frame_count", 32'(frames), 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mmio_tx.md
Name: uart_mmio_tx

Overview:
Memory-mapped UART transmit peripheral that sits downstream of the core's store path, on the same memwrite / alu_result / rs2value signals that feed data_ram. Software writes bytes to a TXDATA register. The bytes are queued in a FIFO and serialised 8N1 on a tx pin. A STATUS register lets firmware poll for space and completion. This replaces hard-wired message ROMs with program-driven output.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate in bit/s; DIV = CLK_FREQ/BAUD_RATE with integer truncation (434 at defaults)
FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, minimum 2
BASE_ADDR, 32'h1000_0000, byte address of TXDATA; STATUS is at BASE_ADDR+4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  store strobe from the core (memwrite)
addr  in  32  byte address (alu_result)
wdata  in  32  store data (rs2value)
sel  out  1  combinational; 1 when addr[31:3]==BASE_ADDR[31:3], so the core muxes rdata over data_ram
rdata  out  32  combinational read data
tx  out  1  serial output, idle high
tx_busy  out  1  1 while a frame is on the line
irq_idle  out  1  1 when FIFO empty and FSM in IDLE

Behaviour:
- Reset (async, immediate): tx=1, tx_busy=0, FIFO flushed (count=0), overflow=0, FSM=IDLE, irq_idle=1. A frame in progress is abandoned with no stop bit.
- Address decode: offset 0x0 is TXDATA, offset 0x4 is STATUS. Offsets 0x1-0x3 and 0x5-0x7 are aliases of their word; addr[1:0] is ignored.
- TXDATA write (we && sel && addr[2]==0): pushes wdata[7:0].
  - Accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set to 1 (sticky).
- STATUS write (we && sel && addr[2]==1): if wdata[3]==1, overflow is cleared. All other bits are ignored.
- Simultaneous overflow-set and clear in the same cycle: clear wins. These cannot occur together, since they target different addresses; this is stated for completeness.
- STATUS read value:
  - [0] tx_busy, [1] empty, [2] full, [3] overflow, [7:4] 0.
  - [15:8] count, zero-extended; count width is clog2(FIFO_DEPTH+1).
  - [31:16] 0.
  - Reset value is 32'h0000_0002.
- TXDATA read: returns 0.
- rdata is 0 when sel==0.
- FIFO: circular buffer with read and write pointers of width clog2(FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH. count is the authoritative full/empty indicator.
- FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..DIV-1 and a bit index runs 0..7.
  - IDLE: if count!=0, pop the head into the shift register at this edge and go to START. tx=0 and tx_busy=1 from this edge; the baud counter is cleared.
  - START: hold tx=0 for DIV cycles, then go to DATA with tx=shift[0] and bit index 0.
  - DATA: each bit is held for DIV cycles, LSB first. After bit 7's DIV cycles, go to STOP with tx=1.
  - STOP: hold tx=1 for DIV cycles, then go to IDLE.
    - Back-to-back rule: if the FIFO is non-empty at that edge, pop immediately and go straight to START, so there is no idle gap.
    - tx_busy deasserts only when entering IDLE with the FIFO empty.
- Frame length is exactly 10*DIV cycles (4340 at defaults).
- Latency: a write sampled at edge k into an empty FIFO with the FSM in IDLE produces tx falling at edge k+1. STATUS reads taken after edge k+1 show count=0 and busy=1.
- tx, tx_busy and irq_idle are registered (or derived only from registered state); no combinational path from wdata to tx.
- Writes while busy are legal and are queued.

Test Plan:
- After reset, read STATUS -> 32'h0000_0002; tx=1; irq_idle=1; sel=0 for addr 32'h0000_0100.
- Write 0x55 to TXDATA -> tx low from the next edge for 434 cycles. Data bits then read 1,0,1,0,1,0,1,0 at 434 cycles each, then stop bit 1 for 434 cycles. tx_busy falls at cycle 4341 after the write.
- Write 0x41 then 0x42 back-to-back -> two frames of 4340 cycles each with no idle cycle between them. STATUS count reads 1 just after the first pop and 0 after the second.
- Write 9 bytes 0x01..0x09 in 9 consecutive cycles starting from IDLE -> the first pop leaves room, so all 9 are accepted; with FIFO_DEPTH=8, count reaches 8 and full=1. A 10th write leaves overflow=1 and count=8. Writing 0x8 to STATUS clears overflow; the 8 queued bytes 0x02..0x09 are still transmitted in order.
- Wrap-around: 20 bytes written at spaced intervals -> the serial output byte sequence matches the input exactly, covering pointer wrap.
- Assert rst in the middle of the DATA state -> tx=1 and tx_busy=0 asynchronously and STATUS=0x2. After release, a new write transmits cleanly with no residue from the old frame.
